// File: rtl/tern_conv3x3_acc_if.sv
// Stream bundle for the ternary 3x3 convolution accumulator: sign-code
// columns and weights in, pixel sums and framing status out.
interface tern_conv3x3_acc_if #(
    parameter int WIDTH_A = 12
);
    logic               i_vsync;
    logic               i_hsync;
    logic               i_reuse;
    logic               i_valid;
    logic [5:0]         i_tdata;
    logic [17:0]        i_wdata;
    logic               o_vsync;
    logic               o_hsync;
    logic               o_reuse;
    logic               o_valid;
    logic [WIDTH_A-1:0] o_tdata;
    logic               o_err;

    modport master (
        output i_vsync, i_hsync, i_reuse, i_valid, i_tdata, i_wdata,
        input  o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_err
    );

    modport slave (
        input  i_vsync, i_hsync, i_reuse, i_valid, i_tdata, i_wdata,
        output o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_err
    );
endinterface

// File: rtl/tern_conv3x3_acc.sv
// Ternary 3x3 convolution accumulator: builds a per-channel 3x3 window from
// buffered columns, multiplies by ternary weights, sums over all channels.
module tern_conv3x3_acc #(
    parameter int WIDTH_A = 12,
    parameter int SIZE    = 56,
    parameter int CHANNEL = 64
) (
    input  logic              i_sclk,
    input  logic              i_rst_n,
    tern_conv3x3_acc_if.slave bus
);
    localparam int XW = $clog2(SIZE + 3);
    localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam logic [XW-1:0] X_DONE  = XW'(SIZE + 2);
    localparam logic [XW-1:0] X_FIRST = XW'(2);
    localparam logic [CW-1:0] C_LAST  = CW'(CHANNEL - 1);

    // 01 = +1, 11 = -1, 00/10 = 0; result uses the same code
    function automatic logic [1:0] tern_mul(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] p;
        if (a[0] && b[0]) begin
            p = (a[1] ^ b[1]) ? 2'b11 : 2'b01;
        end else begin
            p = 2'b00;
        end
        return p;
    endfunction

    logic [XW-1:0]      x_r;
    logic [CW-1:0]      c_r;
    logic               hsync_d_r;
    logic [5:0]         col1_r [CHANNEL];
    logic [5:0]         col2_r [CHANNEL];
    logic               s1_valid_r, s1_last_r, s1_first_r;
    logic [17:0]        s1_prod_r;
    logic               s2_valid_r, s2_last_r, s2_first_r;
    logic [4:0]         s2_sum_r;
    logic [WIDTH_A-1:0] acc_r;
    logic [2:0]         dly0_r, dly1_r, dly2_r;

    logic               hs_rise_s, beat_s, accept_s, excess_s, frame_err_s;
    logic [XW-1:0]      x_eff_s;
    logic [CW-1:0]      c_eff_s;
    logic [17:0]        window_s;
    logic [17:0]        prod_s;
    logic [4:0]         sum_s;
    logic [WIDTH_A-1:0] acc_next_s;

    // Beat classification; a rising hsync restarts the row on this very beat
    always_comb begin
        hs_rise_s = bus.i_hsync & ~hsync_d_r;
        beat_s    = bus.i_valid & ~bus.i_vsync;
        if (hs_rise_s) begin
            x_eff_s = {XW{1'b0}};
            c_eff_s = {CW{1'b0}};
        end else begin
            x_eff_s = x_r;
            c_eff_s = c_r;
        end
        accept_s    = beat_s && (x_eff_s != X_DONE);
        excess_s    = beat_s && (x_eff_s == X_DONE);
        frame_err_s = hs_rise_s && ((c_r != {CW{1'b0}}) || ((x_r != {XW{1'b0}}) && (x_r != X_DONE)));
        window_s    = {col2_r[c_eff_s], col1_r[c_eff_s], bus.i_tdata};
        for (int k = 0; k < 9; k++) begin
            prod_s[2*k +: 2] = tern_mul(window_s[2*k +: 2], bus.i_wdata[2*k +: 2]);
        end
    end

    // Column/channel counters and hsync edge history
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_r       <= {XW{1'b0}};
            c_r       <= {CW{1'b0}};
            hsync_d_r <= 1'b0;
        end else begin
            hsync_d_r <= bus.i_hsync;
            if (bus.i_vsync) begin
                x_r <= {XW{1'b0}};
                c_r <= {CW{1'b0}};
            end else if (accept_s) begin
                if (c_eff_s == C_LAST) begin
                    c_r <= {CW{1'b0}};
                    x_r <= x_eff_s + XW'(1);
                end else begin
                    c_r <= c_eff_s + CW'(1);
                    x_r <= x_eff_s;
                end
            end else if (hs_rise_s) begin
                x_r <= {XW{1'b0}};
                c_r <= {CW{1'b0}};
            end
        end
    end

    // Sticky framing error: excess beats or a row restarted before completion
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_err <= 1'b0;
        end else if (bus.i_vsync) begin
            bus.o_err <= 1'b0;
        end else if (excess_s || frame_err_s) begin
            bus.o_err <= 1'b1;
        end
    end

    // Column history; left uninitialised since x<2 gating hides stale entries
    always_ff @(posedge i_sclk) begin
        if (accept_s) begin
            col2_r[c_eff_s] <= col1_r[c_eff_s];
            col1_r[c_eff_s] <= bus.i_tdata;
        end
    end

    // Nine-term sum of the registered products, two's complement in 5 bits
    always_comb begin
        sum_s = 5'd0;
        for (int k = 0; k < 9; k++) begin
            sum_s = sum_s + {{3{s1_prod_r[2*k+1]}}, s1_prod_r[2*k +: 2]};
        end
        acc_next_s = (s2_first_r ? {WIDTH_A{1'b0}} : acc_r) + {{(WIDTH_A-5){s2_sum_r[4]}}, s2_sum_r};
    end

    // Three-stage pipeline: products, window sum, channel accumulation
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_first_r  <= 1'b0;
            s1_prod_r   <= 18'd0;
            s2_valid_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            s2_first_r  <= 1'b0;
            s2_sum_r    <= 5'd0;
            acc_r       <= {WIDTH_A{1'b0}};
            bus.o_valid <= 1'b0;
            bus.o_tdata <= {WIDTH_A{1'b0}};
        end else if (bus.i_vsync) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            acc_r       <= {WIDTH_A{1'b0}};
            bus.o_valid <= 1'b0;
        end else begin
            s1_valid_r  <= accept_s && (x_eff_s >= X_FIRST);
            s1_last_r   <= (c_eff_s == C_LAST);
            s1_first_r  <= (c_eff_s == {CW{1'b0}});
            s1_prod_r   <= prod_s;
            s2_valid_r  <= s1_valid_r;
            s2_last_r   <= s1_last_r;
            s2_first_r  <= s1_first_r;
            s2_sum_r    <= sum_s;
            bus.o_valid <= s2_valid_r && s2_last_r;
            if (s2_valid_r) begin
                acc_r <= acc_next_s;
            end
            if (s2_valid_r && s2_last_r) begin
                bus.o_tdata <= acc_next_s;
            end
        end
    end

    // Side-band delay line matching the pipeline depth
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dly0_r <= 3'd0;
            dly1_r <= 3'd0;
            dly2_r <= 3'd0;
        end else begin
            dly0_r <= {bus.i_vsync, bus.i_hsync, bus.i_reuse};
            dly1_r <= dly0_r;
            dly2_r <= dly1_r;
        end
    end

    assign bus.o_vsync = dly2_r[2];
    assign bus.o_hsync = dly2_r[1];
    assign bus.o_reuse = dly2_r[0];
endmodule

// File: tb/tb_tern_conv3x3_acc.sv
// Directed self-checking bench: a small instance (SIZE=4, CHANNEL=2) for framing
// and arithmetic cases, and a default-parameter instance for full-size sums.
module tb_tern_conv3x3_acc;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [11:0] sm_q [$];
    logic [11:0] df_q [$];

    localparam logic [5:0]  D_P  = 6'b010101;
    localparam logic [5:0]  D_N  = 6'b111111;
    localparam logic [17:0] W_P  = 18'h15555;
    localparam logic [17:0] W_N  = 18'h3FFFF;
    localparam logic [5:0]  D_M0 = 6'b100111;
    localparam logic [5:0]  D_M1 = 6'b001101;
    localparam logic [17:0] W_M0 = 18'b010101_111001_000111;
    localparam logic [17:0] W_M1 = 18'b111111_011011_111101;

    tern_conv3x3_acc_if #(.WIDTH_A(12)) sm_if ();
    tern_conv3x3_acc_if #(.WIDTH_A(12)) df_if ();

    tern_conv3x3_acc #(.WIDTH_A(12), .SIZE(4), .CHANNEL(2)) u_sm (
        .i_sclk (clk),
        .i_rst_n(rst_n),
        .bus    (sm_if)
    );

    tern_conv3x3_acc u_df (
        .i_sclk (clk),
        .i_rst_n(rst_n),
        .bus    (df_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sm_if.o_valid === 1'b1) sm_q.push_back(sm_if.o_tdata);
        if (df_if.o_valid === 1'b1) df_q.push_back(df_if.o_tdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int n, input logic [11:0] v);
        chk({tag, "_count"}, sm_q.size(), n);
        for (int i = 0; i < sm_q.size(); i++) chk({tag, "_sum"}, sm_q[i], v);
        sm_q.delete();
    endtask

    task automatic sm_drv(input logic v, input logic hs, input logic vs,
                          input logic [5:0] d, input logic [17:0] w);
        sm_if.i_valid = v;
        sm_if.i_hsync = hs;
        sm_if.i_vsync = vs;
        sm_if.i_tdata = d;
        sm_if.i_wdata = w;
        @(posedge clk);
        #1;
    endtask

    task automatic sm_idle(input int n);
        for (int i = 0; i < n; i++) sm_drv(1'b0, 1'b0, 1'b0, 6'd0, 18'd0);
    endtask

    task automatic sm_row(input int n, input logic [5:0] d0, input logic [5:0] d1,
                          input logic [17:0] w0, input logic [17:0] w1);
        for (int b = 0; b < n; b++) begin
            if (b % 2 == 0) sm_drv(1'b1, 1'b1, 1'b0, d0, w0);
            else            sm_drv(1'b1, 1'b1, 1'b0, d1, w1);
        end
        sm_idle(5);
    endtask

    task automatic df_row(input logic [5:0] d);
        for (int b = 0; b < 58 * 64; b++) begin
            df_if.i_valid = 1'b1;
            df_if.i_hsync = 1'b1;
            df_if.i_tdata = d;
            df_if.i_wdata = W_P;
            @(posedge clk);
            #1;
        end
        df_if.i_valid = 1'b0;
        df_if.i_hsync = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sm_if.i_vsync = 1'b0; sm_if.i_hsync = 1'b0; sm_if.i_reuse = 1'b0;
        sm_if.i_valid = 1'b0; sm_if.i_tdata = 6'd0; sm_if.i_wdata = 18'd0;
        df_if.i_vsync = 1'b0; df_if.i_hsync = 1'b0; df_if.i_reuse = 1'b0;
        df_if.i_valid = 1'b0; df_if.i_tdata = 6'd0; df_if.i_wdata = 18'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sm_flags", {sm_if.o_valid, sm_if.o_vsync, sm_if.o_hsync, sm_if.o_reuse, sm_if.o_err}, 5'd0);
        chk("rst_sm_tdata", sm_if.o_tdata, 12'd0);
        chk("rst_df_flags", {df_if.o_valid, df_if.o_vsync, df_if.o_hsync, df_if.o_reuse, df_if.o_err}, 5'd0);
        rst_n = 1'b1;
        sm_idle(2);

        // Cycle-exact row of all +1: strobes 3 cycles after beats 5,7,9,11
        for (int s = 0; s < 15; s++) begin
            sm_if.i_reuse = (s == 4);
            sm_drv(s < 12, s < 12, 1'b0, D_P, W_P);
            chk("pos_valid", sm_if.o_valid, (s == 7) || (s == 9) || (s == 11) || (s == 13));
            if (s == 7 || s == 9 || s == 11 || s == 13) chk("pos_sum", sm_if.o_tdata, 12'd18);
            chk("o_hsync_dly", sm_if.o_hsync, (s >= 2) && (s <= 13));
            chk("o_reuse_dly", sm_if.o_reuse, s == 6);
        end
        sm_if.i_reuse = 1'b0;
        sm_q.delete();

        sm_row(12, D_P, D_P, W_N, W_N);
        chk_q("neg_weight", 4, 12'hFEE);
        sm_row(12, D_P, D_N, W_P, W_P);
        chk_q("alt_channel", 4, 12'd0);
        sm_row(12, D_M0, D_M1, W_M0, W_M1);
        chk_q("mixed_zero_codes", 4, 12'd2);
        chk("err_clean_rows", sm_if.o_err, 1'b0);

        // vsync after 3 beats drops the partial row without flagging it
        for (int b = 0; b < 3; b++) sm_drv(1'b1, 1'b1, 1'b0, D_P, W_P);
        sm_drv(1'b1, 1'b0, 1'b1, D_P, W_P);
        sm_idle(2);
        chk("o_vsync_dly", sm_if.o_vsync, 1'b1);
        sm_idle(1);
        chk("o_vsync_end", sm_if.o_vsync, 1'b0);
        chk("vsync_err", sm_if.o_err, 1'b0);
        chk_q("vsync_no_out", 0, 12'd0);
        sm_row(12, D_P, D_P, W_P, W_P);
        chk_q("after_vsync", 4, 12'd18);
        chk("after_vsync_err", sm_if.o_err, 1'b0);

        // One excess beat after a full row
        sm_row(13, D_P, D_P, W_P, W_P);
        chk_q("excess_row", 4, 12'd18);
        chk("excess_err", sm_if.o_err, 1'b1);
        sm_drv(1'b0, 1'b0, 1'b1, 6'd0, 18'd0);
        chk("vsync_clr_err", sm_if.o_err, 1'b0);
        sm_idle(3);

        // Row restarted after 7 of 12 beats
        sm_row(7, D_P, D_P, W_P, W_P);
        chk("partial_no_err", sm_if.o_err, 1'b0);
        sm_drv(1'b1, 1'b1, 1'b0, D_P, W_P);
        chk("restart_err", sm_if.o_err, 1'b1);
        sm_row(11, D_P, D_P, W_P, W_P);
        chk_q("restart_out", 5, 12'd18);
        chk("restart_err_held", sm_if.o_err, 1'b1);

        // Asynchronous reset while a sum is on the output
        for (int b = 0; b < 8; b++) sm_drv(1'b1, 1'b1, 1'b0, D_P, W_P);
        chk("pre_rst_valid", sm_if.o_valid, 1'b1);
        chk("pre_rst_sum", sm_if.o_tdata, 12'd18);
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {sm_if.o_valid, sm_if.o_hsync, sm_if.o_err}, 3'd0);
        chk("async_rst_tdata", sm_if.o_tdata, 12'd0);
        sm_drv(1'b0, 1'b0, 1'b0, 6'd0, 18'd0);
        rst_n = 1'b1;
        sm_idle(1);
        sm_q.delete();
        sm_row(12, D_P, D_P, W_P, W_P);
        chk_q("after_rst", 4, 12'd18);
        chk("after_rst_err", sm_if.o_err, 1'b0);

        // Default parameters: 64 channels x 9 terms
        df_row(D_P);
        chk("df_pos_count", df_q.size(), 56);
        chk("df_pos_first", df_q[0], 12'h240);
        chk("df_pos_last", df_q[55], 12'h240);
        df_q.delete();
        df_row(D_N);
        chk("df_neg_count", df_q.size(), 56);
        chk("df_neg_first", df_q[0], 12'hDC0);
        chk("df_neg_last", df_q[55], 12'hDC0);
        chk("df_err", df_if.o_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tern_conv3x3_acc.md
# tern_conv3x3_acc

Ternary 3×3 convolution accumulator that sits directly downstream of the row-buffer group's compare/match port. That port delivers a 6-bit column of three ternary sign codes (rows r, r‑1, r‑2) per beat. This block holds the two previous columns per channel, forms the 3×3 window, and multiplies it by a per-beat 3×3 ternary weight. It accumulates over all channels and emits one signed sum per output pixel.

## Interface
- WIDTH_A, 12: signed accumulator/output width (≥ clog2(9·CHANNEL)+1).
- SIZE, 56: unpadded feature-map width; padded row carries SIZE+2 columns.
- CHANNEL, 64: channels per pixel, interleaved channel-minor.
- i_sclk  in  1  clock.
- i_rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- i_vsync  in  1  frame sync; high = synchronous clear of counters, column buffers' read pointers, accumulator, pipeline valids.
- i_hsync  in  1  row active; rising edge starts a row.
- i_reuse  in  1  side flag, carried aligned to data.
- i_valid  in  1  beat valid.
- i_tdata  in  6  {row r, row r‑1, row r‑2}, 2 bits each: 01=+1, 11=−1, 00/10=0.
- i_wdata  in  18  3×3 weight for current beat's channel, same 2-bit code; [17:12]=col x‑2, [11:6]=col x‑1, [5:0]=col x, each column ordered as i_tdata.
- o_vsync, o_hsync, o_reuse  out  1  inputs delayed 3 cycles.
- o_valid  out  1  one-cycle strobe, completed pixel sum.
- o_tdata  out  WIDTH_A  signed two's-complement pixel sum.
- o_err  out  1  sticky framing error; cleared by i_vsync.

## Operation
- Beat index: column counter x (0..SIZE+1), channel counter c (0..CHANNEL‑1); both advance only on i_valid && !i_vsync; c wraps to 0 and increments x.
- Column buffers col1[c], col2[c] (6 bits × CHANNEL each). On accepted beat: window = {col2[c], col1[c], i_tdata}; then col2[c]←col1[c], col1[c]←i_tdata.
- Beats with x<2 update buffers only; no product contributes, no output.
- Products: 9 ternary × ternary → {−1,0,+1}; any 0 operand (00 or 10) gives 0.
- Stage 1: register 9 products + tag (x≥2, c==CHANNEL‑1, c==0). Stage 2: 9-term sum, range −9..+9, 5-bit signed. Stage 3: acc ← (first ? 0 : acc) + sign-extended sum; on last-channel tag, o_tdata ← final sum, o_valid=1.
- No saturation; WIDTH_A is sized so overflow cannot occur.
- Beats after x reaches SIZE+1 with c wrapped (excess beats in a row): ignored, o_err←1.
- i_hsync rising edge: x,c←0. If c≠0 or 0<x<SIZE+2 at that edge (incomplete row), o_err←1 and the partial accumulation is discarded (no o_valid).
- i_vsync high: x,c,acc←0, stage valids←0, o_err←0; beats with i_vsync high are dropped. vsync beats take priority over simultaneous hsync or valid beats.
- Column buffer contents are not cleared by reset or vsync; x<2 gating makes stale contents unobservable.

## Timing
- Reset (i_rst_n=0): all outputs 0, counters 0, acc 0, pipeline valids 0, immediately (asynchronous).
- Latency: last-channel beat accepted at cycle t → o_valid at t+3, o_tdata valid same cycle, held until next o_valid.
- o_vsync/o_hsync/o_reuse: 3-cycle delay, aligned to o_valid.
- Full throughput: one beat per cycle; no back-pressure, no ready signal.
- Per row: SIZE output pixels, one per CHANNEL accepted beats after the first 2·CHANNEL.
- Gaps (i_valid low) anywhere inside a row are legal; state holds.

## Test plan
- SIZE=4, CHANNEL=2; all data 01 and all weights 01 for a 6-column row → 4 o_valid strobes, each o_tdata=+18, first strobe 3 cycles after beat 5 (x=2, c=1).
- Same stimulus, weights all 11 → four sums of −18; alternating data 11 by channel with weights 01 → 0.
- Default parameters, all +1 → o_tdata=576 (0x240 in 12 bits); all −1 data with +1 weights → −576.
- Codes 10 and 00 in data and weights mixed with ±1 → sum matches reference model treating 10 as 0.
- Assert i_vsync mid-row after 3 beats → no o_valid, counters 0, o_err 0; next row produces exact sums.
- Second hsync rising edge after 7 of 12 beats → o_err=1 and held; partial pixel not emitted. Pull i_rst_n low mid-accumulation → all outputs 0 at once.
